// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU classes, ALU control codes, forwarding
// selects and the packed EX/MEM pipeline register layout.
package ex_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] pc_branch;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic [63:0] rs2_data;
    logic [4:0]  rd;
  } exmem_t;

endpackage

// File: rtl/ex_alu.sv
// 64-bit EX-stage ALU. Define EX_EXT_ALU_EN to add XOR, shifts and signed SLT;
// otherwise only AND/OR/ADD/SUB are built.
module ex_alu
  import ex_pkg::*;
(
  input  logic signed [63:0] op_a,
  input  logic signed [63:0] op_b,
  input  logic        [3:0]  alu_ctrl,
  output logic signed [63:0] result,
  output logic               zero
);

  always_comb begin
    result = op_a + op_b;
    case (alu_ctrl)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
`ifdef EX_EXT_ALU_EN
      ALU_XOR: result = op_a ^ op_b;
      ALU_SLL: result = op_a << op_b[5:0];
      ALU_SRL: result = op_a >> op_b[5:0];
      ALU_SRA: result = op_a >>> op_b[5:0];
      ALU_SLT: result = (op_a < op_b) ? 64'sd1 : 64'sd0;
`endif
      default: result = op_a + op_b;
    endcase
  end

  assign zero = (result == 64'sd0);

endmodule

// File: rtl/ex_stage_pipe.sv
// EX stage: forwarding unit, ALU-control decode, branch-target adder and the
// EX/MEM register. EX_EXT_ALU_EN enables the extended ALU operations.
module ex_stage_pipe
  import ex_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic        [63:0] pc,
  input  logic signed [63:0] rs1_data,
  input  logic signed [63:0] rs2_data,
  input  logic        [4:0]  rs1,
  input  logic        [4:0]  rs2,
  input  logic        [4:0]  rd,
  input  logic signed [63:0] imm,
  input  logic        [1:0]  alu_op,
  input  logic               alu_src,
  input  logic        [2:0]  funct3,
  input  logic               funct7b5,
  input  logic               branch,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               mem_to_reg,
  input  logic               reg_write,
  input  logic               flush,
  input  logic               reg_write_wb,
  input  logic        [4:0]  rd_wb,
  input  logic        [63:0] wb_data,
  output logic        [1:0]  forward_a,
  output logic        [1:0]  forward_b,
  output logic               mem_to_reg_d3,
  output logic               reg_write_d3,
  output logic               branch_d3,
  output logic               mem_read_d3,
  output logic               mem_write_d3,
  output logic        [63:0] pc_branch_d3,
  output logic signed [63:0] alu_result_d3,
  output logic               alu_zero_d3,
  output logic signed [63:0] rs2_data_d3,
  output logic        [4:0]  rd_d3
);

  exmem_t             exmem_q, exmem_d;
  logic signed [63:0] fwd_a_data, fwd_b_data, op_b;
  logic signed [63:0] alu_result;
  logic               alu_zero;
  logic        [3:0]  alu_ctrl;

  // EX/MEM hit is checked first so the younger result wins; x0 never forwards.
  // NOTE: every always_comb output gets a default on entry so no path infers a latch.
  always_comb begin
    forward_a = FWD_REG;
    if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == rs1)
      forward_a = FWD_EXMEM;
    else if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs1)
      forward_a = FWD_WB;

    forward_b = FWD_REG;
    if (exmem_q.reg_write && exmem_q.rd != 5'd0 && exmem_q.rd == rs2)
      forward_b = FWD_EXMEM;
    else if (reg_write_wb && rd_wb != 5'd0 && rd_wb == rs2)
      forward_b = FWD_WB;
  end

  always_comb begin
    case (forward_a)
      FWD_EXMEM: fwd_a_data = $signed(exmem_q.alu_result);
      FWD_WB:    fwd_a_data = $signed(wb_data);
      default:   fwd_a_data = rs1_data;
    endcase
    case (forward_b)
      FWD_EXMEM: fwd_b_data = $signed(exmem_q.alu_result);
      FWD_WB:    fwd_b_data = $signed(wb_data);
      default:   fwd_b_data = rs2_data;
    endcase
    op_b = alu_src ? imm : fwd_b_data;
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        // I-type has no SUB, so funct7b5 only matters for R-type funct3 000.
        case (funct3)
          3'b000:  alu_ctrl = (alu_op == ALU_OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
`ifdef EX_EXT_ALU_EN
          3'b100:  alu_ctrl = ALU_XOR;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b010:  alu_ctrl = ALU_SLT;
`endif
          default: alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  ex_alu u_alu (
    .op_a     (fwd_a_data),
    .op_b     (op_b),
    .alu_ctrl (alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  // A flush turns the captured instruction into a bubble.
  always_comb begin
    exmem_d            = '0;
    exmem_d.mem_to_reg = mem_to_reg;
    exmem_d.reg_write  = reg_write;
    exmem_d.branch     = branch;
    exmem_d.mem_read   = mem_read;
    exmem_d.mem_write  = mem_write;
    exmem_d.pc_branch  = pc + (imm <<< 1);
    exmem_d.alu_result = alu_result;
    exmem_d.alu_zero   = alu_zero;
    exmem_d.rs2_data   = fwd_b_data;
    exmem_d.rd         = rd;
    if (flush) exmem_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the whole EX/MEM register is reset, data included, so a post-reset bubble is clean.
  always_ff @(posedge clk) begin
    if (rst) exmem_q <= '0;
    else     exmem_q <= exmem_d;
  end

  assign mem_to_reg_d3 = exmem_q.mem_to_reg;
  assign reg_write_d3  = exmem_q.reg_write;
  assign branch_d3     = exmem_q.branch;
  assign mem_read_d3   = exmem_q.mem_read;
  assign mem_write_d3  = exmem_q.mem_write;
  assign pc_branch_d3  = exmem_q.pc_branch;
  assign alu_result_d3 = $signed(exmem_q.alu_result);
  assign alu_zero_d3   = exmem_q.alu_zero;
  assign rs2_data_d3   = $signed(exmem_q.rs2_data);
  assign rd_d3         = exmem_q.rd;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: a table of ALU/branch-adder vectors plus
// hand sequences for reset, forwarding, branch, flush and x0.
module tb_ex_stage_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic        [63:0] pc;
  logic signed [63:0] rs1_data, rs2_data, imm;
  logic        [4:0]  rs1, rs2, rd, rd_wb;
  logic        [1:0]  alu_op;
  logic               alu_src, funct7b5;
  logic        [2:0]  funct3;
  logic               branch, mem_read, mem_write, mem_to_reg, reg_write;
  logic               flush, reg_write_wb;
  logic        [63:0] wb_data;
  logic        [1:0]  forward_a, forward_b;
  logic               mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3;
  logic        [63:0] pc_branch_d3;
  logic signed [63:0] alu_result_d3, rs2_data_d3;
  logic               alu_zero_d3;
  logic        [4:0]  rd_d3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage_pipe dut (
    .clk(clk), .rst(rst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op), .alu_src(alu_src),
    .funct3(funct3), .funct7b5(funct7b5), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .flush(flush), .reg_write_wb(reg_write_wb), .rd_wb(rd_wb), .wb_data(wb_data),
    .forward_a(forward_a), .forward_b(forward_b),
    .mem_to_reg_d3(mem_to_reg_d3), .reg_write_d3(reg_write_d3), .branch_d3(branch_d3),
    .mem_read_d3(mem_read_d3), .mem_write_d3(mem_write_d3), .pc_branch_d3(pc_branch_d3),
    .alu_result_d3(alu_result_d3), .alu_zero_d3(alu_zero_d3),
    .rs2_data_d3(rs2_data_d3), .rd_d3(rd_d3)
  );

  typedef struct {
    logic [1:0]  op;
    logic        src;
    logic [2:0]  f3;
    logic        f7;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] im;
    logic [63:0] pcv;
    logic [63:0] exp_res;
    logic        exp_zero;
    logic [63:0] exp_pcb;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; alu_op = 2'b00; alu_src = 1'b0;
    funct3 = 3'b000; funct7b5 = 1'b0; branch = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0; flush = 1'b0;
    reg_write_wb = 1'b0; rd_wb = 5'd0; wb_data = '0;
  endtask

  task automatic check_bubble(input string name);
    check({name, "_ctrl"},
          {59'd0, mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3}, 64'd0);
    check({name, "_pcb"}, pc_branch_d3, 64'd0);
    check({name, "_res"}, alu_result_d3, 64'd0);
    check({name, "_zero"}, {63'd0, alu_zero_d3}, 64'd0);
    check({name, "_rs2"}, rs2_data_d3, 64'd0);
    check({name, "_rd"}, {59'd0, rd_d3}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 1'b0, 3'b000, 1'b0, 64'd7, 64'd5, 64'h10, 64'h1000, 64'd12, 1'b0, 64'h1020};
    vecs[1]  = '{2'b01, 1'b0, 3'b000, 1'b0, 64'd5, 64'd5, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0,
                 64'd0, 1'b1, 64'h10};
    vecs[2]  = '{2'b10, 1'b0, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 64'd0, 1'b1, 64'hF8};
    vecs[3]  = '{2'b10, 1'b0, 3'b000, 1'b1, 64'd3, 64'd5, 64'd0, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'd0};
    vecs[4]  = '{2'b10, 1'b0, 3'b111, 1'b0, 64'hF0F0, 64'hFF00, 64'd0, 64'd0, 64'hF000, 1'b0, 64'd0};
    vecs[5]  = '{2'b10, 1'b0, 3'b110, 1'b0, 64'hF0F0, 64'h0F00, 64'd0, 64'd0, 64'hFFF0, 1'b0, 64'd0};
    vecs[6]  = '{2'b11, 1'b1, 3'b000, 1'b1, 64'd100, 64'd555, 64'hFFFF_FFFF_FFFF_FFFF, 64'h200,
                 64'd99, 1'b0, 64'h1FE};
    vecs[7]  = '{2'b11, 1'b1, 3'b111, 1'b0, 64'hFF, 64'd9, 64'h0F, 64'd0, 64'h0F, 1'b0, 64'h1E};
`ifdef EX_EXT_ALU_EN
    vecs[8]  = '{2'b10, 1'b0, 3'b100, 1'b0, 64'd6, 64'd3, 64'd0, 64'd0, 64'd5, 1'b0, 64'd0};
    vecs[9]  = '{2'b10, 1'b0, 3'b001, 1'b0, 64'd1, 64'd4, 64'd0, 64'd0, 64'd16, 1'b0, 64'd0};
    vecs[10] = '{2'b10, 1'b0, 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'd0, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0};
    vecs[11] = '{2'b10, 1'b0, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                 64'd1, 1'b0, 64'd0};
`else
    vecs[8]  = '{2'b10, 1'b0, 3'b100, 1'b0, 64'd6, 64'd3, 64'd0, 64'd0, 64'd9, 1'b0, 64'd0};
    vecs[9]  = '{2'b10, 1'b0, 3'b001, 1'b0, 64'd1, 64'd4, 64'd0, 64'd0, 64'd5, 1'b0, 64'd0};
    vecs[10] = '{2'b10, 1'b0, 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'd0, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 64'd0};
    vecs[11] = '{2'b10, 1'b0, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                 64'd0, 1'b1, 64'd0};
`endif
    vecs[12] = '{2'b11, 1'b0, 3'b011, 1'b1, 64'd2, 64'd3, 64'd0, 64'd0, 64'd5, 1'b0, 64'd0};

    // Reset with a live instruction (and a flush, which reset must dominate).
    idle_inputs();
    rst = 1'b1; flush = 1'b1; reg_write = 1'b1; rd = 5'd5; rs1_data = 64'd3;
    tick();
    check_bubble("reset");
    idle_inputs();
    rs1 = 5'd5;
    #1 check("reset_fwd_a_none", {62'd0, forward_a}, 64'd0);
    reg_write_wb = 1'b1; rd_wb = 5'd5;
    #1 check("reset_fwd_a_wb", {62'd0, forward_a}, 64'd1);

    // Table vectors with no register overlap, so no forwarding is active.
    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      rs1 = 5'd10; rs2 = 5'd11; rd = 5'd20; reg_write = 1'b1;
      alu_op = vecs[i].op; alu_src = vecs[i].src; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
      rs1_data = vecs[i].a; rs2_data = vecs[i].b; imm = vecs[i].im; pc = vecs[i].pcv;
      tick();
      check($sformatf("vec%0d_res", i), alu_result_d3, vecs[i].exp_res);
      check($sformatf("vec%0d_zero", i), {63'd0, alu_zero_d3}, {63'd0, vecs[i].exp_zero});
      check($sformatf("vec%0d_pcb", i), pc_branch_d3, vecs[i].exp_pcb);
      check($sformatf("vec%0d_rs2", i), rs2_data_d3, vecs[i].b);
      check($sformatf("vec%0d_rd", i), {59'd0, rd_d3}, 64'd20);
    end

    // R-type add, then a dependent op forwarded from EX/MEM.
    idle_inputs();
    rs1 = 5'd1; rs2 = 5'd2; rs1_data = 64'd7; rs2_data = 64'd5;
    alu_op = 2'b10; rd = 5'd3; reg_write = 1'b1;
    tick();
    check("raw_res", alu_result_d3, 64'd12);
    check("raw_rd", {59'd0, rd_d3}, 64'd3);
    check("raw_zero", {63'd0, alu_zero_d3}, 64'd0);
    rs1 = 5'd3; rs1_data = 64'd0;
    #1 check("raw_fwd_a", {62'd0, forward_a}, 64'd2);
    check("raw_fwd_b", {62'd0, forward_b}, 64'd0);
    tick();
    check("raw_dep_res", alu_result_d3, 64'd17);

    // Double hazard on a store: EX/MEM outranks MEM/WB for rs2.
    idle_inputs();
    rs1 = 5'd1; rs2 = 5'd2; rs1_data = 64'd4; rs2_data = 64'd5; rd = 5'd4; reg_write = 1'b1;
    tick();
    check("dbl_setup_res", alu_result_d3, 64'd9);
    idle_inputs();
    reg_write_wb = 1'b1; rd_wb = 5'd4; wb_data = 64'd1;
    rs1 = 5'd1; rs1_data = 64'd100; rs2 = 5'd4; rs2_data = 64'd77;
    alu_src = 1'b1; imm = 64'd8; mem_write = 1'b1;
    #1 check("dbl_fwd_b", {62'd0, forward_b}, 64'd2);
    check("dbl_fwd_a", {62'd0, forward_a}, 64'd0);
    tick();
    check("dbl_rs2_d3", rs2_data_d3, 64'd9);
    check("dbl_res", alu_result_d3, 64'd108);
    check("dbl_mem_write", {63'd0, mem_write_d3}, 64'd1);
    // The store did not write a register, so only the MEM/WB match remains.
    mem_write = 1'b0; alu_src = 1'b0; rs1_data = 64'd10;
    #1 check("wb_fwd_b", {62'd0, forward_b}, 64'd1);
    tick();
    check("wb_res", alu_result_d3, 64'd11);
    check("wb_rs2_d3", rs2_data_d3, 64'd1);

    // Branch compare and target.
    idle_inputs();
    rs1 = 5'd6; rs2 = 5'd7; alu_op = 2'b01; rs1_data = 64'd10; rs2_data = 64'd10;
    pc = 64'h40; imm = 64'd8; branch = 1'b1;
    tick();
    check("br_zero", {63'd0, alu_zero_d3}, 64'd1);
    check("br_pcb", pc_branch_d3, 64'h50);
    check("br_branch", {63'd0, branch_d3}, 64'd1);

    // Flush turns a live instruction into a bubble.
    idle_inputs();
    flush = 1'b1; reg_write = 1'b1; mem_write = 1'b1; rd = 5'd7; rs1_data = 64'd3;
    pc = 64'h100; imm = 64'd4;
    tick();
    check_bubble("flush");

    // x0 is never forwarded, from either stage.
    idle_inputs();
    reg_write = 1'b1; rd = 5'd0; rs1_data = 64'd1; rs2_data = 64'd1;
    tick();
    check("x0_setup_rw", {63'd0, reg_write_d3}, 64'd1);
    idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; reg_write_wb = 1'b1; rd_wb = 5'd0;
    #1 check("x0_fwd_a", {62'd0, forward_a}, 64'd0);
    check("x0_fwd_b", {62'd0, forward_b}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 pc  in  64  ID/EX program counter of the instruction in EX.
REQ-004 rs1_data, rs2_data  in  64 signed each  ID/EX register-file operands.
REQ-005 rs1, rs2, rd  in  5 each  ID/EX register addresses.
REQ-006 imm  in  64 signed  ID/EX sign-extended immediate.
REQ-007 alu_op  in  2  ALU class: 00 add, 01 sub, 10 R-type, 11 I-type arithmetic.
REQ-008 alu_src  in  1  operand B select: 0 forwarded rs2, 1 imm.
REQ-009 funct3  in  3 / funct7b5  in  1  instruction function fields.
REQ-010 branch, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  ID/EX control bits.
REQ-011 flush  in  1  taken-branch flush from the MEM stage.
REQ-012 reg_write_wb  in  1 / rd_wb  in  5 / wb_data  in  64  MEM/WB writeback bus used for forwarding.
REQ-013 forward_a, forward_b  out  2 each  combinational forwarding selects.
REQ-014 EX/MEM register outputs:
- mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3: 1 each.
- pc_branch_d3: 64.
- alu_result_d3: 64 signed.
- alu_zero_d3: 1.
- rs2_data_d3: 64 signed.
- rd_d3: 5.

Function
REQ-015 forward_a select:
- 10 if reg_write_d3 && rd_d3!=0 && rd_d3==rs1.
- else 01 if reg_write_wb && rd_wb!=0 && rd_wb==rs1.
- else 00.
- forward_b uses the same rules against rs2.
REQ-016 EX/MEM match outranks MEM/WB match on the same register; x0 is never forwarded.
REQ-017 Forwarded operand: 00 selects rs1_data/rs2_data, 10 selects alu_result_d3, 01 selects wb_data, 11 behaves as 00.
REQ-018 ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0110.
REQ-019 ALU control decode:
- alu_op 00: ADD. alu_op 01: SUB.
- alu_op 10: funct3 000 gives SUB if funct7b5 else ADD; 111 AND; 110 OR.
- alu_op 11: funct3 000 ADD (funct7b5 ignored); 111 AND; 110 OR.
- Any other funct3 decodes to ADD.
REQ-020 ALU arithmetic is 64-bit two's complement, wraps on overflow, has no flags other than zero; alu_zero = (result==0).
REQ-021 pc_branch = pc + (imm<<1), 64-bit wrap.
REQ-022 On each rising edge without rst or flush, every *_d3 loads its EX value (1-cycle latency).
REQ-023 rs2_data_d3 loads the forwarded rs2, never the raw rs2_data.
REQ-024 flush high at an edge clears every *_d3 to 0 (bubble), whatever the inputs.
REQ-025 There is no stall input; an upstream bubble (all control bits 0) passes through unchanged.

Reset
REQ-026 rst high at an edge sets every *_d3 to 0; rst dominates flush.
REQ-027 forward_a and forward_b read 00 in the cycle after reset unless an MEM/WB match exists.

Configuration
REQ-028 With EX_EXT_ALU_EN defined, alu_op 10/11 additionally decode:
- funct3 100 XOR (0011).
- funct3 001 SLL (0100).
- funct3 101 SRL (0101) or SRA (0111) by funct7b5.
- funct3 010 signed SLT (1000).
- Shift amount is operand B[5:0].
REQ-029 Without EX_EXT_ALU_EN, those funct3 values decode to ADD and no shifter or comparator is built.

Structure
REQ-030 Package ex_pkg holds:
- alu_op encodings.
- 4-bit ALU control codes.
- Forward-select constants FWD_REG=00, FWD_WB=01, FWD_EXMEM=10.
REQ-031 One sub-module, ex_alu (operand A, operand B, alu_ctrl -> result, zero); the forwarding unit, ALU-control decode, branch adder and EX/MEM register stay in the top module.

Verification
REQ-032 Reset: rst=1 with reg_write=1, rd=5, rs1_data=3 -> all *_d3=0 after the edge.
REQ-033 R-type add then dependent op:
- rs1_data=7, rs2_data=5, alu_op=10, funct3=000, funct7b5=0, rd=3, reg_write=1 -> alu_result_d3=12, rd_d3=3, alu_zero_d3=0.
- Next cycle rs1=3, rs1_data=0 -> forward_a=10 and the result uses 12.
REQ-034 Double hazard on a store:
- reg_write_d3=1, rd_d3=4, alu_result_d3=9; reg_write_wb=1, rd_wb=4, wb_data=1; rs2=4, mem_write=1, alu_src=1.
- Expect forward_b=10 and rs2_data_d3=9.
REQ-035 Branch: alu_op=01, rs1_data=rs2_data=10, pc=0x40, imm=8, branch=1 -> alu_zero_d3=1, pc_branch_d3=0x50, branch_d3=1.
REQ-036 Flush: flush=1 with reg_write=1, mem_write=1 -> all *_d3=0 after the edge.
REQ-037 x0: reg_write_d3=1, rd_d3=0, rs1=0 -> forward_a=00.
